// File: rtl/camera_pkg.sv
// Shared constants for the camera frame controller: default geometry, stream word layout and
// controller state encodings.
package camera_pkg;

  localparam int unsigned CAM_ADDR_W      = 13;
  localparam int unsigned CAM_FRAME_WORDS = 2400;
  localparam int unsigned CAM_DATA_W      = 32;
  // FIFO entry carries the stream word plus its end-of-frame tag in the MSB
  localparam int unsigned CAM_FIFO_W      = CAM_DATA_W + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  function automatic logic cam_holds_capture(input logic [2:0] st);
    return (st == ST_ARM) || (st == ST_READ) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/frame_rd_fifo.sv
// Two-entry FIFO between the RAM read port and the output stream; each entry is a data word
// plus its last tag. Flush wins over push and pop in the same cycle.
module frame_rd_fifo
  import camera_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [CAM_FIFO_W-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [CAM_FIFO_W-1:0] o_rdata,
  output logic [1:0]            o_count
);

  logic [CAM_FIFO_W-1:0] r_mem0;
  logic [CAM_FIFO_W-1:0] r_mem1;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop  = i_pop & (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wptr) begin
          r_mem1 <= i_wdata;
        end else begin
          r_mem0 <= i_wdata;
        end
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_rptr ? r_mem1 : r_mem0;
  assign o_count = r_count;

endmodule

// File: rtl/camera_frame_ctrl.sv
// Frame controller: arms the capture block, then streams the frozen frame buffer out of the
// dual-port RAM as a 32-bit valid/ready stream with a two-deep read pipeline.
module camera_frame_ctrl
  import camera_pkg::*;
#(
  parameter int unsigned ADDR_W      = CAM_ADDR_W,
  parameter int unsigned FRAME_WORDS = CAM_FRAME_WORDS,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              abort,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_last,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_d;
  logic [23:0]           r_timer;
  logic [ADDR_W-1:0]     r_raddr;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [15:0]           r_frame_cnt;
  logic                  r_no_rearm;

  logic                  w_active;
  logic                  w_lost;
  logic                  w_kill;
  logic                  w_timeout;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_frame_done;
  logic [CAM_FIFO_W-1:0] w_fifo_rdata;
  logic [1:0]            w_fifo_count;

  assign w_active = cam_holds_capture(r_state);
  // Capture releasing the buffer mid-readout means the frame contents can no longer be trusted
  assign w_lost   = ((r_state == ST_READ) || (r_state == ST_DRAIN)) & ~cap_ready;
  assign w_kill   = (w_active & abort) | w_lost;

  assign w_timeout = (r_state == ST_ARM) & ~abort & ~cap_ready & (TIMEOUT_CYC != 24'd0) &
                     (r_timer == (TIMEOUT_CYC - 24'd1));

  assign w_fifo_valid = (w_fifo_count != 2'd0);
  assign w_pop        = w_fifo_valid & ~w_kill & s_ready;

  // Words issued but not yet consumed stay at most two; a pop in this cycle frees a slot
  assign w_credit     = (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2) | w_pop;
  assign w_issue      = (r_state == ST_READ) & ~w_kill & w_credit;
  assign w_issue_last = w_issue & (r_raddr == LAST_ADDR);
  assign w_frame_done = (r_state == ST_DRAIN) & w_pop & w_fifo_rdata[CAM_FIFO_W-1];

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start & ~abort) w_state_d = ST_ARM;
      end
      ST_ARM: begin
        if (abort) begin
          w_state_d = ST_DROP;
        end else if (cap_ready) begin
          w_state_d = ST_READ;
        end else if (w_timeout) begin
          w_state_d = ST_DROP;
        end
      end
      ST_READ: begin
        if (w_kill) begin
          w_state_d = ST_DROP;
        end else if (w_issue_last) begin
          w_state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_kill || w_frame_done) w_state_d = ST_DROP;
      end
      ST_DROP: begin
        if (!cap_ready) begin
          w_state_d = (cont_mode & ~r_no_rearm & ~abort) ? ST_ARM : ST_IDLE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state         <= ST_IDLE;
      r_timer         <= 24'd0;
      r_raddr         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_frame_cnt     <= 16'd0;
      r_no_rearm      <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_timer         <= ((r_state == ST_ARM) && (w_state_d == ST_ARM)) ? r_timer + 24'd1 : 24'd0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;

      if ((r_state == ST_ARM) && (w_state_d == ST_READ)) begin
        r_raddr <= '0;
      end else if (w_issue && !w_issue_last) begin
        r_raddr <= r_raddr + 1'b1;
      end

      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      // Aborted or timed-out frames must not re-arm, even in continuous mode
      if ((r_state == ST_DROP) && (w_state_d != ST_DROP)) begin
        r_no_rearm <= 1'b0;
      end else if ((w_active & abort) | w_timeout | ((r_state == ST_DROP) & abort)) begin
        r_no_rearm <= 1'b1;
      end
    end
  end

  frame_rd_fifo u_fifo (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_flush (w_kill),
    .i_push  (r_inflight),
    .i_wdata ({r_inflight_last, ram_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count)
  );

  assign cap_valid   = w_active;
  assign busy        = (r_state != ST_IDLE);
  assign ram_raddr   = r_raddr;
  assign s_data      = w_fifo_rdata[CAM_DATA_W-1:0];
  assign s_valid     = w_fifo_valid & ~w_kill;
  assign s_last      = w_fifo_rdata[CAM_FIFO_W-1] & s_valid;
  assign frame_done  = w_frame_done;
  assign timeout_err = w_timeout;
  assign frame_cnt   = r_frame_cnt;

endmodule
